// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_sequencer
//  Purpose  : Multi-cycle RV32M multiply/divide unit. Shift-add multiply and
//             restoring divide over a 64-bit accumulator; sign correction and
//             result load in FIX, one-cycle done pulse in DONE.
//  Options  : MULDIV_FAST_MUL_EN - single-cycle product for the four multiply
//             ops, computed at acceptance (divides stay iterative).
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Result
);

    localparam int c_W     = DATA_WIDTH;
    localparam int c_W2    = 2 * DATA_WIDTH;
    localparam int c_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_W-1:0]     c_MIN  = {1'b1, {(c_W-1){1'b0}}};
    localparam logic [c_W-1:0]     c_ONES = {c_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state_q,  w_state_d;
    logic [2:0]           r_op_q,     w_op_d;
    logic                 r_neg_q,    w_neg_d;     // negate product / quotient
    logic                 r_rneg_q,   w_rneg_d;    // remainder takes dividend sign
    logic                 r_spec_q,   w_spec_d;    // special-case result in acc low
    logic [c_W2-1:0]      r_acc_q,    w_acc_d;     // {hi/rem, multiplier/quot}
    logic [c_W-1:0]       r_opnd_q,   w_opnd_d;    // multiplicand / divisor magnitude
    logic [c_CNT_W-1:0]   r_cnt_q,    w_cnt_d;
    logic [c_W-1:0]       r_result_q, w_result_d;
    logic                 r_busy_q,   w_busy_d;
    logic                 r_done_q,   w_done_d;

    // ------------------------------------------------------------------
    // Acceptance-time operand decode
    // ------------------------------------------------------------------
    logic           w_sgn_a, w_sgn_b, w_a_neg, w_b_neg;
    logic [c_W-1:0] w_mag_a, w_mag_b, w_spec_val;
    logic           w_div0, w_ovf;

    // A is signed for MUL/MULH/MULHSU/DIV/REM; B only for MUL/MULH/DIV/REM
    assign w_sgn_a   = !(funct3 inside {3'b011, 3'b101, 3'b111});
    assign w_sgn_b   = funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
    assign w_a_neg   = w_sgn_a & SrcA[c_W-1];
    assign w_b_neg   = w_sgn_b & SrcB[c_W-1];
    assign w_mag_a   = w_a_neg ? (~SrcA + 1'b1) : SrcA;
    assign w_mag_b   = w_b_neg ? (~SrcB + 1'b1) : SrcB;

    assign w_div0    = funct3[2] && (SrcB == '0);
    assign w_ovf     = (funct3 == 3'b100 || funct3 == 3'b110) &&
                       (SrcA == c_MIN) && (SrcB == c_ONES);
    // funct3[1] distinguishes REM/REMU from DIV/DIVU
    assign w_spec_val = w_div0 ? (funct3[1] ? SrcA : c_ONES)
                               : (funct3[1] ? '0   : c_MIN);

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extended 64-bit operands: low 64 bits of the product are exact
    logic [c_W2-1:0] w_fa, w_fb, w_fast_prod;
    assign w_fa        = {{c_W{w_a_neg}}, SrcA};
    assign w_fb        = {{c_W{w_b_neg}}, SrcB};
    assign w_fast_prod = w_fa * w_fb;
`endif

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [c_W:0]    w_mul_sum, w_rem_sh, w_diff;
    logic [c_W2-1:0] w_mul_acc, w_div_acc;

    // Multiply step: conditional add into upper half, then shift pair right
    assign w_mul_sum = {1'b0, r_acc_q[c_W2-1:c_W]} +
                       (r_acc_q[0] ? {1'b0, r_opnd_q} : '0);
    assign w_mul_acc = {w_mul_sum, r_acc_q[c_W-1:1]};

    // Divide step: shift {rem, quot} left, trial-subtract divisor.
    // rem < divisor keeps the shifted value below 2*divisor, so bit c_W of
    // the 33-bit difference is a reliable borrow flag.
    assign w_rem_sh  = {r_acc_q[c_W2-1:c_W], r_acc_q[c_W-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_opnd_q};
    assign w_div_acc = w_diff[c_W] ? {w_rem_sh[c_W-1:0], r_acc_q[c_W-2:0], 1'b0}
                                   : {w_diff[c_W-1:0],   r_acc_q[c_W-2:0], 1'b1};

    // ------------------------------------------------------------------
    // Sign correction and result select
    // ------------------------------------------------------------------
    logic [c_W2-1:0] w_prod;
    logic [c_W-1:0]  w_quo, w_rem, w_fix_result;

    assign w_prod = r_neg_q  ? (~r_acc_q + 1'b1) : r_acc_q;
    assign w_quo  = r_neg_q  ? (~r_acc_q[c_W-1:0] + 1'b1) : r_acc_q[c_W-1:0];
    assign w_rem  = r_rneg_q ? (~r_acc_q[c_W2-1:c_W] + 1'b1) : r_acc_q[c_W2-1:c_W];

    // Pick the architectural result for the latched operation
    always_comb begin
        w_fix_result = '0;
        if (r_spec_q) begin
            w_fix_result = r_acc_q[c_W-1:0];
        end else begin
            case (r_op_q)
                3'b000:                 w_fix_result = w_prod[c_W-1:0];
                3'b001, 3'b010, 3'b011: w_fix_result = w_prod[c_W2-1:c_W];
                3'b100, 3'b101:         w_fix_result = w_quo;
                default:                w_fix_result = w_rem;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic for the sequencer and all datapath registers
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state_q;
        w_op_d     = r_op_q;
        w_neg_d    = r_neg_q;
        w_rneg_d   = r_rneg_q;
        w_spec_d   = r_spec_q;
        w_acc_d    = r_acc_q;
        w_opnd_d   = r_opnd_q;
        w_cnt_d    = r_cnt_q;
        w_result_d = r_result_q;
        w_busy_d   = r_busy_q;
        w_done_d   = 1'b0;

        case (r_state_q)
            S_IDLE, S_DONE: begin
                w_state_d = S_IDLE;
                w_busy_d  = 1'b0;
                if (start) begin
                    w_op_d    = funct3;
                    w_neg_d   = w_a_neg ^ w_b_neg;
                    w_rneg_d  = w_a_neg;
                    w_spec_d  = 1'b0;
                    w_cnt_d   = '0;
                    w_busy_d  = 1'b1;
                    w_state_d = S_ITER;
                    if (funct3[2]) begin
                        w_opnd_d = w_mag_b;
                        w_acc_d  = {{c_W{1'b0}}, w_mag_a};
                    end else begin
                        w_opnd_d = w_mag_a;
                        w_acc_d  = {{c_W{1'b0}}, w_mag_b};
                    end
                    if (w_div0 || w_ovf) begin
                        w_spec_d  = 1'b1;
                        w_acc_d   = {{c_W{1'b0}}, w_spec_val};
                        w_state_d = S_FIX;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    if (!funct3[2]) begin
                        w_acc_d   = w_fast_prod;
                        w_neg_d   = 1'b0;
                        w_state_d = S_FIX;
                    end
`endif
                end
            end
            S_ITER: begin
                w_acc_d = r_op_q[2] ? w_div_acc : w_mul_acc;
                w_cnt_d = r_cnt_q + 1'b1;
                if (r_cnt_q == c_LAST) begin
                    w_state_d = S_FIX;
                end
            end
            S_FIX: begin
                w_result_d = w_fix_result;
                w_done_d   = 1'b1;
                w_busy_d   = 1'b0;
                w_state_d  = S_DONE;
            end
            default: begin
                w_state_d = S_IDLE;
                w_busy_d  = 1'b0;
            end
        endcase

        // Flush wins over everything, including a same-cycle start
        if (abort) begin
            w_state_d  = S_IDLE;
            w_busy_d   = 1'b0;
            w_done_d   = 1'b0;
            w_result_d = r_result_q;
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= S_IDLE;
            r_op_q     <= '0;
            r_neg_q    <= 1'b0;
            r_rneg_q   <= 1'b0;
            r_spec_q   <= 1'b0;
            r_acc_q    <= '0;
            r_opnd_q   <= '0;
            r_cnt_q    <= '0;
            r_result_q <= '0;
            r_busy_q   <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_op_q     <= w_op_d;
            r_neg_q    <= w_neg_d;
            r_rneg_q   <= w_rneg_d;
            r_spec_q   <= w_spec_d;
            r_acc_q    <= w_acc_d;
            r_opnd_q   <= w_opnd_d;
            r_cnt_q    <= w_cnt_d;
            r_result_q <= w_result_d;
            r_busy_q   <= w_busy_d;
            r_done_q   <= w_done_d;
        end
    end

    assign busy   = r_busy_q;
    assign done   = r_done_q;
    assign Result = r_result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_sequencer
//  Purpose  : Self-checking bench for muldiv_sequencer: directed operations
//             with literal results, plus a per-cycle comparison of busy/done/
//             Result against a transaction-level timing and arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] SrcA = 32'd0;
    logic [31:0] SrcB = 32'd0;
    logic        busy, done;
    logic [31:0] Result;

    always #5 clk = ~clk;

    muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .Result (Result)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference arithmetic (RV32M semantics) ----------------
    function automatic logic [31:0] ref_fn(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 64'd0;
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Cycles from the accepting cycle to the done cycle
    function automatic int lat_fn(input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b);
        if (f[2] && b == 32'd0) return 2;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 2;
`endif
        return 34;
    endfunction

    // ---------------- transaction-level model ----------------
    int          cyc = 0;
    bit          m_active = 1'b0;
    int          m_acc = 0;
    int          m_done = 0;
    logic [31:0] m_pend = 32'd0;
    logic [31:0] m_result = 32'd0;

    always @(posedge clk or posedge rst) begin : model
        automatic bit act;
        if (rst) begin
            m_active <= 1'b0;
            m_result <= 32'd0;
        end else begin
            act = m_active;
            if (abort) begin
                act = 1'b0;
            end else begin
                if (act && cyc == m_done - 1) m_result <= m_pend;
                if (!act || cyc == m_done) begin
                    act = 1'b0;
                    if (start) begin
                        act = 1'b1;
                        m_acc  <= cyc;
                        m_done <= cyc + lat_fn(funct3, SrcA, SrcB);
                        m_pend <= ref_fn(funct3, SrcA, SrcB);
                    end
                end
            end
            m_active <= act;
            cyc <= cyc + 1;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle_check();
        chk("done",   {31'd0, done}, {31'd0, m_active && cyc == m_done});
        chk("busy",   {31'd0, busy}, {31'd0, m_active && cyc > m_acc && cyc < m_done});
        chk("Result", Result, m_result);
    endtask

    task automatic tick();
        @(negedge clk);
        cycle_check();
    endtask

    // Drive one start pulse; n returns the accepting cycle
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int n);
        funct3 = f;
        SrcA   = a;
        SrcB   = b;
        start  = 1'b1;
        n      = cyc;
        tick();
        start  = 1'b0;
    endtask

    // Wait (bounded) for done; returns the done cycle and busy-cycle count
    task automatic wait_done(input string name, output int dcyc, output int bcnt);
        bit found;
        found = 1'b0;
        bcnt  = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            if (busy) bcnt++;
            tick();
        end
        dcyc = cyc;
        chk({name, "_done_seen"}, {31'd0, found}, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit);
        int n, dc, bn, l;
        chk({"model_", name}, ref_fn(f, a, b), lit);
        l = lat_fn(f, a, b);
        issue(f, a, b, n);
        wait_done(name, dc, bn);
        chk(name, Result, lit);
        chk({name, "_latency"}, dc - n, l);
        chk({name, "_busy_cycles"}, bn, l - 1);
        tick();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : stim
        int n, n2, dc, dc1, bn, nd;
        logic [31:0] held;

        repeat (3) tick();
        chk("reset_busy",   {31'd0, busy}, 32'd0);
        chk("reset_done",   {31'd0, done}, 32'd0);
        chk("reset_Result", Result, 32'd0);
        rst = 1'b0;
        tick();

        // MUL 7 * -3, with explicit latency pins
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, n);
        wait_done("mul", dc, bn);
        chk("mul", Result, 32'hFFFF_FFEB);
`ifdef MULDIV_FAST_MUL_EN
        chk("mul_latency", dc - n, 32'd2);
        chk("mul_busy_cycles", bn, 32'd1);
`else
        chk("mul_latency", dc - n, 32'd34);
        chk("mul_busy_cycles", bn, 32'd33);
`endif
        tick();

        run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mul_big",3'd0, 32'h0001_2345, 32'h0000_1000, 32'h1234_5000);
        run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("div_nd", 3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_op("rem_nd", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1);
        run_op("divu",   3'd5, 32'd100, 32'd7, 32'd14);
        run_op("remu",   3'd7, 32'd100, 32'd7, 32'd2);
        run_op("divu_big", 3'd5, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);
        run_op("divu0",  3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("rem0",   3'd6, 32'd5, 32'd0, 32'd5);
        run_op("div_ovf",3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Abort in cycle N+10 of a DIV: no done, Result holds 0
        issue(3'd4, 32'd1000, 32'd3, n);
        while (cyc < n + 10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy_low", {31'd0, busy}, 32'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) nd++;
            tick();
        end
        chk("abort_no_done", nd, 32'd0);
        chk("abort_result_held", Result, 32'd0);

        // Start held high while busy, with changing operands: ignored
        funct3 = 3'd5; SrcA = 32'd100; SrcB = 32'd7; start = 1'b1;
        n = cyc;
        tick();
        funct3 = 3'd0; SrcA = 32'd50;
        repeat (20) tick();
        start = 1'b0;
        wait_done("held", dc, bn);
        chk("held_result", Result, 32'd14);
        chk("held_latency", dc - n, 32'd34);
        tick();

        // Back-to-back: second start in the DONE cycle of the first
        issue(3'd7, 32'd100, 32'd7, n);
        wait_done("b2b_first", dc1, bn);
        chk("b2b_first", Result, 32'd2);
        issue(3'd5, 32'd200, 32'd7, n2);
        chk("b2b_accept_cycle", n2, dc1);
        wait_done("b2b_second", dc, bn);
        chk("b2b_second", Result, 32'd28);
        chk("b2b_gap", dc - dc1, 32'd34);
        tick();

        // Asynchronous reset in the middle of an operation
        held = Result;
        chk("pre_reset_result", held, 32'd28);
        issue(3'd6, 32'd77, 32'd5, n);
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy",   {31'd0, busy}, 32'd0);
        chk("async_rst_done",   {31'd0, done}, 32'd0);
        chk("async_rst_Result", Result, 32'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        run_op("post_reset", 3'd6, 32'd77, 32'd5, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle execution unit for the RV32M multiply/divide instructions. It sits beside the main ALU in the execute stage. It accepts one operation per start pulse, runs a sequenced shift-add multiply or restoring divide over an internal datapath, and holds `busy` so the pipeline stalls. It returns a registered 32-bit result with a one-cycle `done` pulse. Operation selection uses the instruction's funct3 field, with the same encoding the control unit decodes for OP-class instructions with funct7 = 0000001.

## Interface
- `DATA_WIDTH`, default 32: operand and result width; only 32 is supported.
- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request an operation; sampled only in IDLE or DONE.
- `funct3`  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcA`  in  DATA_WIDTH  rs1 operand (multiplicand / dividend); sampled with `start`.
- `SrcB`  in  DATA_WIDTH  rs2 operand (multiplier / divisor); sampled with `start`.
- `abort`  in  1  flush: cancel any in-flight operation.
- `busy`  out  1  high in ITER and FIX; the pipeline stalls while high.
- `done`  out  1  single-cycle pulse; `Result` is valid.
- `Result`  out  DATA_WIDTH  registered result, held until the next completion.

## Operation
- FSM states: IDLE, ITER, FIX, DONE.
- Acceptance: `start` is accepted in IDLE or DONE; it is ignored in ITER and FIX.
- On acceptance:
  - latch funct3 and the operand signs;
  - convert operands to magnitudes (signed for MUL/MULH/DIV/REM; A only for MULHSU; none for MULHU/DIVU/REMU);
  - clear the 64-bit accumulator and the 5-bit counter.
- ITER, multiply: each cycle, if the multiplier LSB is 1, add the multiplicand into the accumulator upper half; then shift the {acc, multiplier} pair right by 1.
- ITER, divide (restoring): each cycle, shift {rem, quot} left by 1; trial-subtract the divisor from rem; if the result is non-negative, keep it and set quot[0].
- ITER ends after 32 cycles (counter 0..31, exit when counter = 31); state then goes to FIX.
- FIX: apply sign correction and load `Result`.
  - Product: negate the 64-bit value if the signs differ. MUL takes [31:0]; MULH/MULHSU/MULHU take [63:32].
  - Quotient: negate if the signs differ.
  - Remainder: takes the dividend's sign.
- DONE: `done` = 1 for this cycle; with no new start, the next state is IDLE.
- Special cases are decided at acceptance; the FSM goes directly to FIX, skipping ITER:
  - divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → SrcA;
  - signed overflow (SrcA = 0x80000000, SrcB = 0xFFFFFFFF): DIV → 0x80000000; REM → 0x00000000.
- `abort`: from any state, the next state is IDLE. `done` does not fire and `Result` keeps its prior value. `abort` wins over a simultaneous `start`.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `Result` 0, counter 0, accumulator 0.
- `start` accepted in cycle N:
  - iterative path: ITER in N+1..N+32, FIX in N+33, `done` in N+34;
  - special-case path: FIX in N+1, `done` in N+2.
- `busy` is high exactly during the ITER and FIX cycles and low in DONE. A new `start` can therefore be accepted in the DONE cycle (back-to-back operation, zero bubble).
- `Result` updates on the FIX→DONE edge and is stable from the DONE cycle onward.
- Reset asserted mid-operation returns all state to the reset values immediately (asynchronous).

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - the four multiply ops use a single-cycle 33×33 signed product computed on acceptance;
  - the FSM goes directly to FIX, so `done` occurs in N+2;
  - divide ops are unchanged.
- `MULDIV_FAST_MUL_EN` undefined: multiplies use the 32-cycle shift-add path, with `done` in N+34.

## Test plan
- MUL with SrcA=7, SrcB=-3 (0xFFFFFFFD) → Result 0xFFFFFFEB; `done` in N+34 (N+2 with the fast-multiply macro); `busy` high for 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with `done` in N+2; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0.
- `abort` in cycle N+10 of a DIV → IDLE in N+11, no `done`, `Result` unchanged; `start` held high during `busy` → ignored; new `start` in the DONE cycle → accepted, second `done` 34 cycles later.
